// File: rtl/trail_pkg.sv
// rtl/trail_pkg.sv - shared constants, state encoding and per-slot ageing for the trail store
package trail_pkg;

  localparam int N_TRAIL  = 41;
  localparam int MAX_LIFE = 10;
  localparam int DRIFT_X  = 4;

  localparam logic [1:0] GM_START = 2'b00;
  localparam logic [1:0] GM_GAME  = 2'b01;
  localparam logic [1:0] GM_PAUSE = 2'b10;
  localparam logic [1:0] GM_OVER  = 2'b11;

  typedef enum logic [1:0] {IDLE, CLEAR, AGE, SPAWN} trail_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [3:0] life;
  } slot_age_t;

  // A particle that cannot drift a full step is killed in place so x never wraps.
  function automatic slot_age_t age_slot(input logic [9:0] x, input logic [3:0] life);
    slot_age_t r;
    r.x    = x;
    r.life = life;
    if (life != 4'd0) begin
      if (x < 10'(DRIFT_X)) begin
        r.life = 4'd0;
      end else begin
        r.x    = x - 10'(DRIFT_X);
        r.life = life - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/trail_scheduler.sv
// rtl/trail_scheduler.sv - per-frame serial update of the trail particle store
// Sole writer of trail_x/trail_y/trail_life; one slot is touched per clock during a pass.
module trail_scheduler
  import trail_pkg::*;
#(
  parameter int SPAWN_DIV   = 2,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic [1:0]                gamemode,
  input  logic [8:0]                player_y,
  output logic [N_TRAIL-1:0][9:0]   trail_x,
  output logic [N_TRAIL-1:0][8:0]   trail_y,
  output logic [N_TRAIL-1:0][3:0]   trail_life,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

  trail_state_t state, state_nxt;
  logic [5:0]    idx;
  logic [5:0]    wr_ptr;
  logic [CW-1:0] spawn_cnt;
  logic [1:0]    mode_l;
  logic [8:0]    py_l;

  logic          last;
  logic          spawn_hit;
  slot_age_t     aged;

  logic          wr_en;
  logic [5:0]    wr_idx;
  logic [9:0]    wr_x;
  logic [8:0]    wr_y;
  logic [3:0]    wr_life;

  assign last      = (idx == 6'(N_TRAIL - 1));
  assign spawn_hit = (spawn_cnt == CW'(SPAWN_DIV - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = idx;
    wr_x      = trail_x[idx];
    wr_y      = trail_y[idx];
    wr_life   = trail_life[idx];
    aged      = age_slot(trail_x[idx], trail_life[idx]);

    case (state)
      IDLE: begin
        if (frame_tick) begin
          case (gamemode)
            GM_START:         state_nxt = CLEAR;
            GM_GAME, GM_OVER: state_nxt = AGE;
            default:          state_nxt = IDLE;
          endcase
        end
      end

      CLEAR: begin
        wr_en   = 1'b1;
        wr_x    = 10'd0;
        wr_y    = 9'd0;
        wr_life = 4'd0;
        if (last) state_nxt = IDLE;
      end

      AGE: begin
        wr_en   = (trail_life[idx] != 4'd0);
        wr_x    = aged.x;
        wr_life = aged.life;
        if (last) state_nxt = (mode_l == GM_GAME) ? SPAWN : IDLE;
      end

      SPAWN: begin
        // The oldest slot is recycled whether or not it is still alive.
        if (spawn_hit) begin
          wr_en   = 1'b1;
          wr_idx  = wr_ptr;
          wr_x    = 10'(PLAYER_X);
          wr_y    = py_l + 9'(PLAYER_SIZE / 2);
          wr_life = 4'(MAX_LIFE);
        end
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 6'd0;
      wr_ptr     <= 6'd0;
      spawn_cnt  <= '0;
      mode_l     <= GM_START;
      py_l       <= 9'd0;
      overrun    <= 1'b0;
      trail_x    <= '0;
      trail_y    <= '0;
      trail_life <= '0;
    end else begin
      state <= state_nxt;

      if (wr_en) begin
        trail_x[wr_idx]    <= wr_x;
        trail_y[wr_idx]    <= wr_y;
        trail_life[wr_idx] <= wr_life;
      end

      if (frame_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          idx <= 6'd0;
          if (frame_tick) begin
            mode_l <= gamemode;
            py_l   <= player_y;
          end
        end

        CLEAR: begin
          idx <= last ? 6'd0 : idx + 6'd1;
          if (last) begin
            wr_ptr    <= 6'd0;
            spawn_cnt <= '0;
          end
        end

        AGE: idx <= last ? 6'd0 : idx + 6'd1;

        SPAWN: begin
          if (spawn_hit) begin
            wr_ptr    <= (wr_ptr == 6'(N_TRAIL - 1)) ? 6'd0 : wr_ptr + 6'd1;
            spawn_cnt <= '0;
          end else begin
            spawn_cnt <= spawn_cnt + CW'(1);
          end
        end

        default: idx <= 6'd0;
      endcase
    end
  end

endmodule
